// File: rtl/alarm_clock_core.sv
// 24-hour alarm clock: debounced buttons, HH:MM seven-segment display, N_ALARMS alarms, ringing FSM.
// Optional snooze state is built only when SNOOZE_EN is defined.
module alarm_clock_core #(
    parameter int CLK_HZ     = 50000000,
    parameter int N_ALARMS   = 2,
    parameter int DEB_CYCLES = 1000000,
    parameter int BUZZ_DIV   = 25000,
    parameter int SNOOZE_MIN = 5,
    localparam int SEL_W     = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          mode,
    input  logic [SEL_W-1:0]    alarm_sel,
    input  logic                btn_hours,
    input  logic                btn_minutes,
    input  logic                btn_off,
    input  logic [N_ALARMS-1:0] alarm_en,
    output logic [6:0]          seg3,
    output logic [6:0]          seg2,
    output logic [6:0]          seg1,
    output logic [6:0]          seg0,
    output logic [1:0]          leds,
    output logic                buzz
);
    localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int BW = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;

`ifdef SNOOZE_EN
    localparam int SNZ_T = SNOOZE_MIN * 60;
    localparam int SW    = $clog2(SNZ_T + 1);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RINGING = 2'd1, S_SNOOZE = 2'd2} state_t;
    logic [SW-1:0] snz_q, snz_d;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RINGING = 2'd1} state_t;
`endif

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [4:0]    hh_q, hh_d;
    logic [5:0]    mm_q, mm_d, ss_q, ss_d;
    logic [4:0]    al_hh_q [N_ALARMS];
    logic [4:0]    al_hh_d [N_ALARMS];
    logic [5:0]    al_mm_q [N_ALARMS];
    logic [5:0]    al_mm_d [N_ALARMS];
    logic [2:0]    s1_q, s1_d, s2_q, s2_d;
    logic [DW-1:0] deb_q [3];
    logic [DW-1:0] deb_d [3];
    logic [5:0]    ring_cnt_q, ring_cnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          buzz_q, buzz_d, led0_q, led0_d, led1_q, led1_d;
    logic [6:0]    seg_q [4];
    logic [6:0]    seg_d [4];

    logic       run, set_clk, set_al, tick, match, start_ring, sel_ok;
    logic [2:0] press;
    logic [4:0] disp_h, h_t, h_o;
    logic [5:0] disp_m, m_t, m_o;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        run     = (mode == 2'b00) || (mode == 2'b11);
        set_clk = (mode == 2'b01);
        set_al  = (mode == 2'b10);
        sel_ok  = (32'(alarm_sel) < N_ALARMS);
        tick    = (tick_cnt_q == TW'(CLK_HZ - 1));

        // press[0]=hours, press[1]=minutes, press[2]=off; one pulse when the level reaches DEB_CYCLES
        s1_d = {btn_off, btn_minutes, btn_hours};
        s2_d = s1_q;
        for (int i = 0; i < 3; i++) begin
            deb_d[i] = deb_q[i];
            press[i] = s2_q[i] && (deb_q[i] == DW'(DEB_CYCLES - 1));
            if (!s2_q[i])
                deb_d[i] = '0;
            else if (deb_q[i] != DW'(DEB_CYCLES))
                deb_d[i] = deb_q[i] + 1'b1;
        end

        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        hh_d = hh_q;
        mm_d = mm_q;
        ss_d = ss_q;
        if (set_clk) begin
            tick_cnt_d = '0;
            ss_d = '0;
            if (press[0]) hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
            if (press[1]) mm_d = (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
        end else if (tick) begin
            if (ss_q != 6'd59) begin
                ss_d = ss_q + 6'd1;
            end else begin
                ss_d = '0;
                if (mm_q != 6'd59) begin
                    mm_d = mm_q + 6'd1;
                end else begin
                    mm_d = '0;
                    hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
                end
            end
        end

        for (int k = 0; k < N_ALARMS; k++) begin
            al_hh_d[k] = al_hh_q[k];
            al_mm_d[k] = al_mm_q[k];
        end
        if (set_al && sel_ok) begin
            if (press[0]) al_hh_d[alarm_sel] = (al_hh_q[alarm_sel] == 5'd23) ? 5'd0 : al_hh_q[alarm_sel] + 5'd1;
            if (press[1]) al_mm_d[alarm_sel] = (al_mm_q[alarm_sel] == 6'd59) ? 6'd0 : al_mm_q[alarm_sel] + 6'd1;
        end

        // match is evaluated against the time this tick produces
        match = 1'b0;
        for (int k = 0; k < N_ALARMS; k++)
            if (alarm_en[k] && al_hh_q[k] == hh_d && al_mm_q[k] == mm_d) match = 1'b1;
        match = match && run && tick && (ss_d == 6'd0);

        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        start_ring = 1'b0;
`ifdef SNOOZE_EN
        snz_d = snz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (match) begin
                    state_d    = S_RINGING;
                    start_ring = 1'b1;
                end
            end
            S_RINGING: begin
                if (press[2]) begin
                    state_d = S_IDLE;
`ifdef SNOOZE_EN
                end else if (press[0]) begin
                    state_d = S_SNOOZE;
                    snz_d   = '0;
`endif
                end else if (tick) begin
                    if (ring_cnt_q == 6'd59) state_d = S_IDLE;
                    else ring_cnt_d = ring_cnt_q + 6'd1;
                end
            end
`ifdef SNOOZE_EN
            S_SNOOZE: begin
                if (press[2]) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (snz_q == SW'(SNZ_T - 1)) begin
                        state_d    = S_RINGING;
                        start_ring = 1'b1;
                    end else begin
                        snz_d = snz_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (!run) begin
            state_d    = S_IDLE;
            start_ring = 1'b0;
        end

        // outputs follow the next state so they change on the same edge as the FSM
        buzz_d = buzz_q;
        bcnt_d = bcnt_q;
        if (start_ring) begin
            ring_cnt_d = '0;
            buzz_d     = 1'b1;
            bcnt_d     = '0;
        end else if (state_d == S_RINGING) begin
            if (bcnt_q == BW'(BUZZ_DIV - 1)) begin
                bcnt_d = '0;
                buzz_d = ~buzz_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end else begin
            buzz_d = 1'b0;
            bcnt_d = '0;
        end
        led0_d = (state_d == S_RINGING) && !ring_cnt_d[0];
        led1_d = |alarm_en;

        disp_h = hh_q;
        disp_m = mm_q;
        if (set_al) begin
            disp_h = sel_ok ? al_hh_q[alarm_sel] : 5'd0;
            disp_m = sel_ok ? al_mm_q[alarm_sel] : 6'd0;
        end
        h_t = disp_h / 5'd10;
        h_o = disp_h % 5'd10;
        m_t = disp_m / 6'd10;
        m_o = disp_m % 6'd10;
        seg_d[3] = seg7(h_t[3:0]);
        seg_d[2] = seg7(h_o[3:0]);
        seg_d[1] = seg7(m_t[3:0]);
        seg_d[0] = seg7(m_o[3:0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            hh_q       <= '0;
            mm_q       <= '0;
            ss_q       <= '0;
            for (int k = 0; k < N_ALARMS; k++) begin
                al_hh_q[k] <= '0;
                al_mm_q[k] <= '0;
            end
            s1_q <= '0;
            s2_q <= '0;
            for (int i = 0; i < 3; i++) deb_q[i] <= '0;
            ring_cnt_q <= '0;
            bcnt_q     <= '0;
            buzz_q     <= 1'b0;
            led0_q     <= 1'b0;
            led1_q     <= 1'b0;
            for (int j = 0; j < 4; j++) seg_q[j] <= 7'b1000000;
`ifdef SNOOZE_EN
            snz_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            for (int k = 0; k < N_ALARMS; k++) begin
                al_hh_q[k] <= al_hh_d[k];
                al_mm_q[k] <= al_mm_d[k];
            end
            s1_q <= s1_d;
            s2_q <= s2_d;
            for (int i = 0; i < 3; i++) deb_q[i] <= deb_d[i];
            ring_cnt_q <= ring_cnt_d;
            bcnt_q     <= bcnt_d;
            buzz_q     <= buzz_d;
            led0_q     <= led0_d;
            led1_q     <= led1_d;
            for (int j = 0; j < 4; j++) seg_q[j] <= seg_d[j];
`ifdef SNOOZE_EN
            snz_q <= snz_d;
`endif
        end
    end

    assign seg3 = seg_q[3];
    assign seg2 = seg_q[2];
    assign seg1 = seg_q[1];
    assign seg0 = seg_q[0];
    assign leds = {led1_q, led0_q};
    assign buzz = buzz_q;
endmodule

// File: tb/tb_alarm_clock_core.sv
// Bench for alarm_clock_core at CLK_HZ=10, DEB_CYCLES=3, BUZZ_DIV=2, SNOOZE_MIN=1.
// Snooze scenarios are compiled in when SNOOZE_EN is defined.
module tb_alarm_clock_core;
    localparam int CLK_HZ = 10;
    localparam int N_AL   = 2;
    localparam int DEB    = 3;
    localparam int BDIV   = 2;
    localparam int SNZ    = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [0:0]  alarm_sel;
    logic        btn_hours, btn_minutes, btn_off;
    logic [1:0]  alarm_en;
    logic [6:0]  seg3, seg2, seg1, seg0;
    logic [1:0]  leds;
    logic        buzz;
    wire  [27:0] disp = {seg3, seg2, seg1, seg0};

    int total = 0;
    int bad   = 0;
    logic [27:0] exp_q[$];
    logic [0:0]  bexp_q[$];

    alarm_clock_core #(
        .CLK_HZ(CLK_HZ), .N_ALARMS(N_AL), .DEB_CYCLES(DEB), .BUZZ_DIV(BDIV), .SNOOZE_MIN(SNZ)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .alarm_sel(alarm_sel),
        .btn_hours(btn_hours), .btn_minutes(btn_minutes), .btn_off(btn_off),
        .alarm_en(alarm_en), .seg3(seg3), .seg2(seg2), .seg1(seg1), .seg0(seg0),
        .leds(leds), .buzz(buzz)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] t [10];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return t[d];
    endfunction

    function automatic logic [27:0] disp_of(input int h, input int m);
        return {seg_of(h / 10), seg_of(h % 10), seg_of(m / 10), seg_of(m % 10)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 hours, 1 minutes, 2 off
    task automatic press(input int which, input int len);
        @(negedge clk);
        case (which)
            0: btn_hours = 1'b1;
            1: btn_minutes = 1'b1;
            default: btn_off = 1'b1;
        endcase
        cyc(len);
        btn_hours = 1'b0;
        btn_minutes = 1'b0;
        btn_off = 1'b0;
        cyc(5);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        mode = 2'b00;
        alarm_sel = 1'b0;
        btn_hours = 1'b0;
        btn_minutes = 1'b0;
        btn_off = 1'b0;
        cyc(3);
        reset = 1'b0;
    endtask

    // reset, alarm[0]=00:01 enabled, then run from 00:00:00 with a zeroed tick counter
    task automatic arm_one_minute;
        do_reset;
        alarm_en = 2'b01;
        mode = 2'b10;
        alarm_sel = 1'b0;
        press(1, 5);
        mode = 2'b01;
        cyc(3);
        mode = 2'b00;
    endtask

    task automatic test_reset;
        logic [27:0] e;
        reset = 1'b1;
        mode = 2'b00;
        alarm_sel = 1'b0;
        btn_hours = 1'b0;
        btn_minutes = 1'b0;
        btn_off = 1'b0;
        alarm_en = 2'b00;
        cyc(4);
        exp_q.push_back(disp_of(0, 0));
        e = exp_q.pop_front();
        total++;
        if (disp !== e) begin bad++; $display("FAIL reset_segs got=%h exp=%h", disp, e); end
        total++;
        if (leds !== 2'b00) begin bad++; $display("FAIL reset_leds got=%b exp=00", leds); end
        total++;
        if (buzz !== 1'b0) begin bad++; $display("FAIL reset_buzz got=%b exp=0", buzz); end
        reset = 1'b0;
    endtask

    task automatic test_run_600;
        logic [27:0] e;
        exp_q.push_back(disp_of(0, 10));
        cyc(6005);
        e = exp_q.pop_front();
        total++;
        if (disp !== e) begin bad++; $display("FAIL run600 got=%h exp=%h", disp, e); end
        total++;
        if (leds !== 2'b00) begin bad++; $display("FAIL run600_leds got=%b exp=00", leds); end
    endtask

    task automatic test_set_clock;
        logic [27:0] e;
        do_reset;
        mode = 2'b01;
        cyc(2);
        btn_minutes = 1'b1;
        cyc(2);
        btn_minutes = 1'b0;
        cyc(8);
        exp_q.push_back(disp_of(0, 0));
        e = exp_q.pop_front();
        total++;
        if (disp !== e) begin bad++; $display("FAIL glitch got=%h exp=%h", disp, e); end

        repeat (61) press(1, 5);
        exp_q.push_back(disp_of(0, 1));
        e = exp_q.pop_front();
        total++;
        if (disp !== e) begin bad++; $display("FAIL min_wrap got=%h exp=%h", disp, e); end

        repeat (58) press(1, 5);
        repeat (24) press(0, 5);
        exp_q.push_back(disp_of(0, 59));
        e = exp_q.pop_front();
        total++;
        if (disp !== e) begin bad++; $display("FAIL hour_wrap got=%h exp=%h", disp, e); end

        repeat (23) press(0, 5);
        exp_q.push_back(disp_of(23, 59));
        exp_q.push_back(disp_of(23, 59));
        exp_q.push_back(disp_of(0, 0));
        e = exp_q.pop_front();
        total++;
        if (disp !== e) begin bad++; $display("FAIL set_2359 got=%h exp=%h", disp, e); end

        mode = 2'b00;
        cyc(595);
        e = exp_q.pop_front();
        total++;
        if (disp !== e) begin bad++; $display("FAIL pre_midnight got=%h exp=%h", disp, e); end
        cyc(10);
        e = exp_q.pop_front();
        total++;
        if (disp !== e) begin bad++; $display("FAIL midnight got=%h exp=%h", disp, e); end
    endtask

    task automatic test_alarm_ring;
        logic [27:0] e;
        logic [0:0]  be;
        logic        seen;
        int          n;
        do_reset;
        alarm_en = 2'b10;
        mode = 2'b10;
        alarm_sel = 1'b1;
        repeat (2) press(1, 5);
        exp_q.push_back(disp_of(0, 2));
        exp_q.push_back(disp_of(0, 0));
        e = exp_q.pop_front();
        total++;
        if (disp !== e) begin bad++; $display("FAIL alarm1_disp got=%h exp=%h", disp, e); end
        total++;
        if (leds[1] !== 1'b1) begin bad++; $display("FAIL led1 got=%b exp=1", leds[1]); end
        alarm_sel = 1'b0;
        cyc(2);
        e = exp_q.pop_front();
        total++;
        if (disp !== e) begin bad++; $display("FAIL alarm0_disp got=%h exp=%h", disp, e); end

        mode = 2'b01;
        cyc(3);
        mode = 2'b00;
        n = 0;
        while (buzz !== 1'b1 && n < 1300) begin @(negedge clk); n++; end
        total++;
        if (n != 1200) begin bad++; $display("FAIL ring_time got=%0d exp=1200", n); end

        for (int i = 0; i < 8; i++) bexp_q.push_back(((i % 4) < 2) ? 1'b1 : 1'b0);
        for (int i = 0; i < 8; i++) begin
            be = bexp_q.pop_front();
            total++;
            if (buzz !== be[0]) begin bad++; $display("FAIL buzz_wave[%0d] got=%b exp=%b", i, buzz, be); end
            @(negedge clk);
        end
        total++;
        if (leds[0] !== 1'b1) begin bad++; $display("FAIL led0_even got=%b exp=1", leds[0]); end
        cyc(4);
        total++;
        if (leds[0] !== 1'b0) begin bad++; $display("FAIL led0_odd got=%b exp=0", leds[0]); end

        cyc(578);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin if (buzz === 1'b1) seen = 1'b1; @(negedge clk); end
        total++;
        if (seen !== 1'b1) begin bad++; $display("FAIL ring_before_timeout got=%b exp=1", seen); end
        cyc(3);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin if (buzz !== 1'b0 || leds[0] !== 1'b0) seen = 1'b1; @(negedge clk); end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL timeout_idle got=%b exp=0", seen); end
        exp_q.push_back(disp_of(0, 3));
        e = exp_q.pop_front();
        total++;
        if (disp !== e) begin bad++; $display("FAIL after_ring_disp got=%h exp=%h", disp, e); end
    endtask

    task automatic test_btn_off_double;
        logic [27:0] e;
        logic        seen;
        int          n;
        mode = 2'b10;
        alarm_sel = 1'b1;
        repeat (3) press(1, 5);
        alarm_sel = 1'b0;
        repeat (5) press(1, 5);
        alarm_en = 2'b11;
        exp_q.push_back(disp_of(0, 5));
        e = exp_q.pop_front();
        total++;
        if (disp !== e) begin bad++; $display("FAIL alarm0_set got=%h exp=%h", disp, e); end

        mode = 2'b01;
        cyc(3);
        mode = 2'b00;
        n = 0;
        while (buzz !== 1'b1 && n < 1300) begin @(negedge clk); n++; end
        total++;
        if (n != 1200) begin bad++; $display("FAIL double_ring_time got=%0d exp=1200", n); end
        cyc(20);
`ifndef SNOOZE_EN
        press(0, 5);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin if (buzz === 1'b1) seen = 1'b1; @(negedge clk); end
        total++;
        if (seen !== 1'b1) begin bad++; $display("FAIL hours_ignored_ringing got=%b exp=1", seen); end
`endif
        btn_off = 1'b1;
        cyc(DEB + 3);
        btn_off = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin if (buzz !== 1'b0 || leds[0] !== 1'b0) seen = 1'b1; @(negedge clk); end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL btn_off_silence got=%b exp=0", seen); end

        press(0, 5);
        press(1, 5);
        exp_q.push_back(disp_of(0, 5));
        e = exp_q.pop_front();
        total++;
        if (disp !== e) begin bad++; $display("FAIL run_buttons_ignored got=%h exp=%h", disp, e); end
    endtask

`ifdef SNOOZE_EN
    task automatic test_snooze;
        logic seen;
        int   n;
        arm_one_minute;
        n = 0;
        while (buzz !== 1'b1 && n < 700) begin @(negedge clk); n++; end
        total++;
        if (n != 600) begin bad++; $display("FAIL snz_ring_time got=%0d exp=600", n); end
        cyc(20);
        btn_hours = 1'b1;
        cyc(DEB + 3);
        btn_hours = 1'b0;
        total++;
        if (buzz !== 1'b0 || leds[0] !== 1'b0) begin bad++; $display("FAIL snooze_silence got=%b%b exp=00", buzz, leds[0]); end
        n = 0;
        while (buzz !== 1'b1 && n < 700) begin @(negedge clk); n++; end
        total++;
        if (n < 585 || n > 605) begin bad++; $display("FAIL snooze_rering got=%0d exp=585..605", n); end
        cyc(5);
        press(0, 5);
        press(2, 5);
        seen = 1'b0;
        for (int i = 0; i < 650; i++) begin if (buzz !== 1'b0) seen = 1'b1; @(negedge clk); end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL snooze_off got=%b exp=0", seen); end
    endtask
`endif

    task automatic test_reset_mid_ring;
        logic [27:0] e;
        logic        seen;
        int          n;
        arm_one_minute;
        n = 0;
        while (buzz !== 1'b1 && n < 700) begin @(negedge clk); n++; end
        total++;
        if (n != 600) begin bad++; $display("FAIL rst_ring_time got=%0d exp=600", n); end
        cyc(7);
        #2 reset = 1'b1;
        #1;
        exp_q.push_back(disp_of(0, 0));
        total++;
        if (buzz !== 1'b0) begin bad++; $display("FAIL async_reset_buzz got=%b exp=0", buzz); end
        e = exp_q.pop_front();
        total++;
        if (disp !== e) begin bad++; $display("FAIL async_reset_segs got=%h exp=%h", disp, e); end
        total++;
        if (leds !== 2'b00) begin bad++; $display("FAIL async_reset_leds got=%b exp=00", leds); end
        cyc(2);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin if (buzz !== 1'b0) seen = 1'b1; @(negedge clk); end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL no_resume got=%b exp=0", seen); end
    endtask

    initial begin
        test_reset;
        test_run_600;
        test_set_clock;
        test_alarm_ring;
        test_btn_off_double;
`ifdef SNOOZE_EN
        test_snooze;
`endif
        test_reset_mid_ring;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
